// File: rtl/lcd1602_bus_receiver.sv
// Snoops an HD44780 write bus and mirrors the 16x2 LCD DDRAM, CGRAM and mode state.
// Optional CGRAM storage: define LCD_RX_CGRAM_EN.
module lcd1602_bus_receiver #(
  parameter int CMD_CYCLES   = 4,
  parameter int CLEAR_CYCLES = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_enable,
  input  logic [7:0] lcd_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  input  logic [5:0] cg_rd_addr,
  output logic [4:0] cg_rd_data,
  output logic [6:0] ac,
  output logic       ac_cgram,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       inc_dir,
  output logic       shift_en,
  output logic       busy,
  output logic       cmd_stb,
  output logic       overrun,
  output logic       rd_err
);

  typedef enum logic [1:0] {IDLE, CLEAR, BUSY_WAIT} state_t;

  state_t      state;
  logic [10:0] s1, s2;
  logic        en_d;
  logic        xfer, x_rs, x_rw;
  logic [7:0]  x_data;
  logic [15:0] cnt, lim;
  logic [4:0]  clr_idx;
  logic [7:0]  ddram [32];

  function automatic logic [6:0] ac_step(
    input logic [6:0] a,
    input logic       cg,
    input logic       up
  );
    logic [6:0] r;
    if (cg)
      r = {1'b0, up ? a[5:0] + 6'd1 : a[5:0] - 6'd1};
    else if (up)
      r = (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
    else
      r = (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
    return r;
  endfunction

  // xfer marks the synchronized enable falling edge, one cycle before it is acted on
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= '0;
      s2     <= '0;
      en_d   <= 1'b0;
      xfer   <= 1'b0;
      x_rs   <= 1'b0;
      x_rw   <= 1'b0;
      x_data <= '0;
    end else begin
      s1     <= {lcd_rs, lcd_rw, lcd_enable, lcd_data};
      s2     <= s1;
      en_d   <= s2[8];
      xfer   <= en_d & ~s2[8];
      x_rs   <= s2[10];
      x_rw   <= s2[9];
      x_data <= s2[7:0];
    end
  end

  assign busy = (state != IDLE);

`ifdef LCD_RX_CGRAM_EN
  logic [4:0] cgram [64];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lim       <= '0;
      clr_idx   <= '0;
      ac        <= '0;
      ac_cgram  <= 1'b0;
      disp_on   <= 1'b0;
      cursor_on <= 1'b0;
      blink_on  <= 1'b0;
      inc_dir   <= 1'b1;
      shift_en  <= 1'b0;
      cmd_stb   <= 1'b0;
      overrun   <= 1'b0;
      rd_err    <= 1'b0;
      for (int i = 0; i < 32; i++) ddram[i] <= 8'h20;
`ifdef LCD_RX_CGRAM_EN
      for (int i = 0; i < 64; i++) cgram[i] <= '0;
`endif
    end else begin
      cmd_stb <= 1'b0;
      rd_err  <= xfer & x_rw;
      overrun <= xfer & ~x_rw & (state != IDLE);
      unique case (state)
        IDLE: begin
          if (xfer && !x_rw) begin
            cmd_stb <= 1'b1;
            cnt     <= 16'd1;
            lim     <= 16'(CMD_CYCLES);
            state   <= BUSY_WAIT;
            if (x_rs) begin
              if (!ac_cgram) begin
                if (ac[5:4] == 2'b00)
                  ddram[{ac[6], ac[3:0]}] <= x_data;
              end else begin
`ifdef LCD_RX_CGRAM_EN
                cgram[ac[5:0]] <= x_data[4:0];
`endif
              end
              ac <= ac_step(ac, ac_cgram, inc_dir);
            end else begin
              unique casez (x_data)
                8'b1???????: begin
                  ac <= (x_data[5:0] > 6'h27) ? {x_data[6], 6'd0}
                                              : x_data[6:0];
                  ac_cgram <= 1'b0;
                end
                8'b01??????: begin
                  ac       <= {1'b0, x_data[5:0]};
                  ac_cgram <= 1'b1;
                end
                // function set has no observable effect on the mirror
                8'b001?????: ;
                8'b0001????: begin
                  if (!x_data[3])
                    ac <= ac_step(ac, ac_cgram, x_data[2]);
                end
                8'b00001???: begin
                  disp_on   <= x_data[2];
                  cursor_on <= x_data[1];
                  blink_on  <= x_data[0];
                end
                8'b000001??: begin
                  inc_dir  <= x_data[1];
                  shift_en <= x_data[0];
                end
                8'b0000001?: begin
                  ac       <= '0;
                  ac_cgram <= 1'b0;
                  lim      <= 16'(CLEAR_CYCLES);
                end
                8'b00000001: begin
                  state   <= CLEAR;
                  clr_idx <= '0;
                  lim     <= 16'(CLEAR_CYCLES);
                end
                default: ;
              endcase
            end
          end
        end
        CLEAR: begin
          ddram[clr_idx] <= 8'h20;
          clr_idx        <= clr_idx + 5'd1;
          cnt            <= cnt + 16'd1;
          if (clr_idx == 5'd31) begin
            state    <= BUSY_WAIT;
            ac       <= '0;
            ac_cgram <= 1'b0;
            inc_dir  <= 1'b1;
          end
        end
        BUSY_WAIT: begin
          if (cnt >= lim) state <= IDLE;
          else cnt <= cnt + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_char <= 8'h20;
    else rd_char <= ddram[rd_addr];
  end

`ifdef LCD_RX_CGRAM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cg_rd_data <= '0;
    else cg_rd_data <= cgram[cg_rd_addr];
  end
`else
  logic unused_cg;
  assign unused_cg  = ^cg_rd_addr;
  assign cg_rd_data = '0;
`endif

endmodule

// File: tb/tb_lcd1602_bus_receiver.sv
// Randomized scoreboard bench for lcd1602_bus_receiver.
// Expected responses come from a linear-position model of the LCD.
module tb_lcd1602_bus_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       lcd_rs, lcd_rw, lcd_enable;
  logic [7:0] lcd_data;
  logic [4:0] rd_addr;
  logic [7:0] rd_char;
  logic [5:0] cg_rd_addr;
  logic [4:0] cg_rd_data;
  logic [6:0] ac;
  logic       ac_cgram, disp_on, cursor_on, blink_on, inc_dir, shift_en;
  logic       busy, cmd_stb, overrun, rd_err;

  lcd1602_bus_receiver dut (
    .clk(clk), .rst(rst),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_enable(lcd_enable),
    .lcd_data(lcd_data),
    .rd_addr(rd_addr), .rd_char(rd_char),
    .cg_rd_addr(cg_rd_addr), .cg_rd_data(cg_rd_data),
    .ac(ac), .ac_cgram(ac_cgram),
    .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .inc_dir(inc_dir), .shift_en(shift_en),
    .busy(busy), .cmd_stb(cmd_stb), .overrun(overrun), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int ac;
    int cg;
    int flags;
    int blen;
    bit chk;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   npulse   = 0;

  // model: DDRAM cursor kept as linear position 0..79 over the two 40-char lines
  int m_p, m_cga, m_cg, m_disp, m_cur, m_blink, m_inc, m_shift;
  int m_dd[32];
  int m_cgr[64];

  function automatic void check(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void m_reset();
    m_p = 0; m_cga = 0; m_cg = 0;
    m_disp = 0; m_cur = 0; m_blink = 0; m_inc = 1; m_shift = 0;
    for (int i = 0; i < 32; i++) m_dd[i] = 32;
    for (int i = 0; i < 64; i++) m_cgr[i] = 0;
  endfunction

  function automatic int m_ac();
    return m_cg ? m_cga : (m_p / 40) * 64 + m_p % 40;
  endfunction

  function automatic int m_flags();
    return m_disp * 16 + m_cur * 8 + m_blink * 4 + m_inc * 2 + m_shift;
  endfunction

  function automatic void m_step(int up);
    if (m_cg) m_cga = (m_cga + (up ? 1 : 63)) % 64;
    else m_p = (m_p + (up ? 1 : 79)) % 80;
  endfunction

  function automatic int dut_flags();
    return int'({disp_on, cursor_on, blink_on, inc_dir, shift_en});
  endfunction

  // returns busy length; chk=0 when the pulse-time state is not final
  function automatic int m_apply(int rs, int d, output bit chk);
    int blen = 4;
    chk = 1;
    if (rs) begin
      if (!m_cg) begin
        if (m_p % 40 < 16) m_dd[(m_p / 40) * 16 + m_p % 40] = d;
      end else begin
`ifdef LCD_RX_CGRAM_EN
        m_cgr[m_cga] = d % 32;
`endif
      end
      m_step(m_inc);
    end else if (d >= 128) begin
      int low = d % 128;
      int col = low % 64;
      if (col > 39) col = 0;
      m_p  = (low / 64) * 40 + col;
      m_cg = 0;
    end else if (d >= 64) begin
      m_cga = d % 64;
      m_cg  = 1;
    end else if (d >= 32) begin
    end else if (d >= 16) begin
      if ((d / 8) % 2 == 0) m_step((d / 4) % 2);
    end else if (d >= 8) begin
      m_disp = (d / 4) % 2; m_cur = (d / 2) % 2; m_blink = d % 2;
    end else if (d >= 4) begin
      m_inc = (d / 2) % 2; m_shift = d % 2;
    end else if (d >= 2) begin
      m_p = 0; m_cg = 0; blen = 40;
    end else if (d == 1) begin
      for (int i = 0; i < 32; i++) m_dd[i] = 32;
      m_p = 0; m_cg = 0; m_inc = 1; blen = 40; chk = 0;
    end
    return blen;
  endfunction

  // kind: 0 accepted, 1 overrun, 2 read error
  task automatic send(input bit rs, input bit rw, input logic [7:0] d,
                      input bit wait_idle, input int kind);
    exp_t e;
    bit   c;
    int   t;
    e.kind = kind; e.blen = 0; e.chk = 1;
    if (kind == 0) begin
      e.blen = m_apply(int'(rs), int'(d), c);
      e.chk  = c;
    end else if (kind == 1) begin
      e.chk = 0;
    end
    e.ac = m_ac(); e.cg = m_cg; e.flags = m_flags();
    q.push_back(e);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_enable = 1'b1;
    repeat (3) @(negedge clk);
    lcd_enable = 1'b0;
    repeat (6) @(negedge clk);
    if (wait_idle) begin
      t = 0;
      while (busy && t < 100) begin
        @(negedge clk);
        t++;
      end
      check("busy_timeout", int'(busy), 0);
      check("idle_ac", int'(ac), m_ac());
      check("idle_ac_cgram", int'(ac_cgram), m_cg);
      check("idle_flags", dut_flags(), m_flags());
      check("pending", q.size(), 0);
    end
  endtask

  task automatic check_mem();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rd_addr = 5'(i);
      @(negedge clk);
      check($sformatf("ddram[%0d]", i), int'(rd_char), m_dd[i]);
    end
    for (int i = 0; i < 64; i += 3) begin
      @(negedge clk);
      cg_rd_addr = 6'(i);
      @(negedge clk);
      check($sformatf("cgram[%0d]", i), int'(cg_rd_data), m_cgr[i]);
    end
  endtask

  int   bcnt, exp_bl, act_kind;
  bit   counting = 0;
  exp_t me;

  always @(negedge clk) begin
    if (rst) begin
      counting = 0;
    end else begin
      if (counting) begin
        if (busy) bcnt++;
        else begin
          check("busy_len", bcnt, exp_bl);
          counting = 0;
        end
      end
      if (cmd_stb || overrun || rd_err) begin
        npulse++;
        act_kind = cmd_stb ? 0 : overrun ? 1 : 2;
        if (q.size() == 0) begin
          check("unexpected_pulse", act_kind, -1);
        end else begin
          me = q.pop_front();
          check("pulse_kind", act_kind, me.kind);
          if (me.chk) begin
            check("ac", int'(ac), me.ac);
            check("ac_cgram", int'(ac_cgram), me.cg);
            check("flags", dut_flags(), me.flags);
          end
          if (act_kind == 0) begin
            counting = 1;
            bcnt     = busy ? 1 : 0;
            exp_bl   = me.blen;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int np;
  int r;

  initial begin
    rst = 1'b1;
    lcd_rs = 0; lcd_rw = 0; lcd_enable = 0; lcd_data = 0;
    rd_addr = 0; cg_rd_addr = 0;
    m_reset();
    repeat (3) @(negedge clk);
    check("rst_rd_char", int'(rd_char), 8'h20);
    check("rst_ac", int'(ac), 0);
    check("rst_flags", dut_flags(), 5'b00010);
    check("rst_busy", int'(busy), 0);
    check("rst_cg_rd", int'(cg_rd_data), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("no_xfer_at_release", npulse, 0);

    send(0, 0, 8'h0C, 1, 0);
    check("disp_on", int'(disp_on), 1);
    send(0, 0, 8'h80, 1, 0);
    send(1, 0, 8'h41, 1, 0);
    send(1, 0, 8'h42, 1, 0);
    check("ac_0x02", int'(ac), 2);
    send(0, 0, 8'hA7, 1, 0);
    send(1, 0, 8'h58, 1, 0);
    send(1, 0, 8'h58, 1, 0);
    check("ac_0x41", int'(ac), 8'h41);
    send(0, 0, 8'h48, 1, 0);
    send(1, 0, 8'h1F, 1, 0);
    send(1, 0, 8'h11, 1, 0);
    check("ac_0x0a", int'(ac), 8'h0A);
    send(1, 1, 8'h33, 1, 2);
    check_mem();

    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      send(1, 0, 8'($urandom), 1, 0);
      else if (r < 50) send(0, 0, 8'h80 | 8'($urandom_range(0, 127)), 1, 0);
      else if (r < 56) send(0, 0, 8'h40 | 8'($urandom_range(0, 63)), 1, 0);
      else if (r < 64) send(0, 0, 8'h10 | 8'($urandom_range(0, 15)), 1, 0);
      else if (r < 70) send(0, 0, 8'h08 | 8'($urandom_range(0, 7)), 1, 0);
      else if (r < 76) send(0, 0, 8'h04 | 8'($urandom_range(0, 3)), 1, 0);
      else if (r < 80) send(0, 0, 8'h20 | 8'($urandom_range(0, 31)), 1, 0);
      else if (r < 84) send(0, 0, 8'h02 | 8'($urandom_range(0, 1)), 1, 0);
      else if (r < 86) send(0, 0, 8'h01, 1, 0);
      else if (r < 88) send(0, 0, 8'h00, 1, 0);
      else if (r < 94) send($urandom_range(0, 1) == 1, 1, 8'($urandom), 1, 2);
      else             send(1, 0, 8'h80 | 8'($urandom), 1, 0);
    end
    check_mem();

    send(0, 0, 8'h80, 1, 0);
    for (int i = 0; i < 16; i++) send(1, 0, 8'h61 + 8'(i), 1, 0);
    send(0, 0, 8'h01, 0, 0);
    send(1, 0, 8'h5A, 1, 1);
    check("clear_ac", int'(ac), 0);
    check("clear_inc", int'(inc_dir), 1);
    check_mem();

    send(0, 0, 8'h0F, 1, 0);
    send(0, 0, 8'h80, 1, 0);
    send(1, 0, 8'h51, 1, 0);
    @(negedge clk);
    rd_addr = 0;
    @(negedge clk);
    check("pre_rst_char", int'(rd_char), 8'h51);
    send(0, 0, 8'h01, 0, 0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_busy", int'(busy), 0);
    check("async_ac", int'(ac), 0);
    check("async_flags", dut_flags(), 5'b00010);
    check("async_rd_char", int'(rd_char), 8'h20);
    check("async_cg_rd", int'(cg_rd_data), 0);
    check("async_stb", int'(cmd_stb), 0);
    q.delete();
    m_reset();
    np = npulse;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("no_xfer_after_rst", npulse, np);
    send(0, 0, 8'h06, 1, 0);
    check_mem();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
